// File: rtl/sram_ctrl_pkg.sv
//==============================================================================
// sram_ctrl_pkg : shared state encoding, lane derivation and default timing
// Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package sram_ctrl_pkg;

    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_RD_WAIT = 2;
    localparam int DEF_WR_WAIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_TURN    = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_HOLD = 3'd4
    } state_t;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

    // One spare bit over the largest load value keeps the counter width >= 1.
    function automatic int cnt_width(input int rd_wait, input int wr_wait);
        int m;
        m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_wait_cnt.sv
//==============================================================================
// sram_wait_cnt : loadable down-counter with a done flag for strobe timing
// Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_wait_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/sram_sync_ctrl.sv
//==============================================================================
// sram_sync_ctrl : valid/ready front end sequencing async byte-lane SRAM strobes
// Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_sync_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int RD_WAIT = DEF_RD_WAIT,
    parameter  int WR_WAIT = DEF_WR_WAIT,
    localparam int NB      = lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [NB-1:0]     req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [NB-1:0]     sram_be_n
);

    localparam int CW = cnt_width(RD_WAIT, WR_WAIT);

    state_t            state;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_en;
    logic [DATA_W-1:0] lane_mask;
    logic              accept;
    logic              cnt_load;
    logic              cnt_dec;
    logic [CW-1:0]     cnt_val;
    logic              cnt_done;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        cnt_load = accept;
        cnt_dec  = (state == ST_RD) || (state == ST_WR);
        cnt_val  = req_we ? CW'(WR_WAIT - 1) : CW'(RD_WAIT - 1);
    end

    sram_wait_cnt #(
        .WIDTH (CW)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // The live be_n pins still hold the request's enables on the sampling edge.
    generate
        for (genvar i = 0; i < NB; i++) begin : g_lane_mask
            assign lane_mask[8*i +: 8] = {8{~sram_be_n[i]}};
        end
    endgenerate

    assign sram_dq = drive_en ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
            sram_addr <= '0;
            drive_en  <= 1'b0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        sram_addr <= req_addr;
                        sram_be_n <= ~req_be;
                        sram_ce_n <= 1'b0;
                        if (req_we) begin
                            state     <= ST_WR;
                            sram_we_n <= 1'b0;
                            wdata_q   <= req_wdata;
                            drive_en  <= 1'b1;
                        end else begin
                            state     <= ST_RD;
                            sram_oe_n <= 1'b0;
                        end
                    end
                end
                ST_RD: begin
                    if (cnt_done) begin
                        rsp_rdata <= sram_dq & lane_mask;
                        rsp_valid <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= '1;
                        state     <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_WR: begin
                    if (cnt_done) begin
                        sram_we_n <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_WR_HOLD;
                    end
                end
                ST_WR_HOLD: begin
                    // Data and CE outlive the WE rising edge by one cycle for hold time.
                    rsp_valid <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_be_n <= '1;
                    drive_en  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_be_n <= '1;
                    drive_en  <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_sync_ctrl.sv
//==============================================================================
// tb_sram_sync_ctrl : scoreboard bench for the default and a widened controller
// Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_sync_ctrl;

    localparam int AW_A = 9,  DW_A = 16, NB_A = 2, RW_A = 2, WW_A = 2;
    localparam int AW_B = 12, DW_B = 32, NB_B = 4, RW_B = 3, WW_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // ---------------- DUT A (default parameters) ----------------
    logic            req_valid_a = 1'b0, req_we_a = 1'b0;
    logic [AW_A-1:0] req_addr_a = '0;
    logic [DW_A-1:0] req_wdata_a = '0;
    logic [NB_A-1:0] req_be_a = '0;
    logic            req_ready_a, rsp_valid_a, ce_n_a, oe_n_a, we_n_a;
    logic [DW_A-1:0] rsp_rdata_a;
    logic [AW_A-1:0] addr_a;
    logic [NB_A-1:0] be_n_a;
    wire  [DW_A-1:0] dq_a;

    sram_sync_ctrl #(.ADDR_W(AW_A), .DATA_W(DW_A), .RD_WAIT(RW_A), .WR_WAIT(WW_A)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_be(req_be_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .sram_addr(addr_a), .sram_dq(dq_a),
        .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a), .sram_be_n(be_n_a)
    );

    // ---------------- DUT B (widened, asymmetric waits) ----------------
    logic            req_valid_b = 1'b0, req_we_b = 1'b0;
    logic [AW_B-1:0] req_addr_b = '0;
    logic [DW_B-1:0] req_wdata_b = '0;
    logic [NB_B-1:0] req_be_b = '0;
    logic            req_ready_b, rsp_valid_b, ce_n_b, oe_n_b, we_n_b;
    logic [DW_B-1:0] rsp_rdata_b;
    logic [AW_B-1:0] addr_b;
    logic [NB_B-1:0] be_n_b;
    wire  [DW_B-1:0] dq_b;

    sram_sync_ctrl #(.ADDR_W(AW_B), .DATA_W(DW_B), .RD_WAIT(RW_B), .WR_WAIT(WW_B)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .sram_addr(addr_b), .sram_dq(dq_b),
        .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b), .sram_be_n(be_n_b)
    );

    // ---------------- async SRAM models (whole word driven on read) ----------------
    logic [DW_A-1:0] mem_a [0:(1<<AW_A)-1];
    logic [DW_B-1:0] mem_b [0:(1<<AW_B)-1];
    logic [DW_A-1:0] sh_a  [0:(1<<AW_A)-1];
    logic [DW_B-1:0] sh_b  [0:(1<<AW_B)-1];

    initial begin
        for (int i = 0; i < (1<<AW_A); i++) begin mem_a[i] = '0; sh_a[i] = '0; end
        for (int i = 0; i < (1<<AW_B); i++) begin mem_b[i] = '0; sh_b[i] = '0; end
    end

    assign dq_a = (!ce_n_a && !oe_n_a && we_n_a) ? mem_a[addr_a] : {DW_A{1'bz}};
    assign dq_b = (!ce_n_b && !oe_n_b && we_n_b) ? mem_b[addr_b] : {DW_B{1'bz}};

    always @(posedge we_n_a)
        if (!rst && !ce_n_a)
            for (int i = 0; i < NB_A; i++) if (!be_n_a[i]) mem_a[addr_a][8*i +: 8] = dq_a[8*i +: 8];
    always @(posedge we_n_b)
        if (!rst && !ce_n_b)
            for (int i = 0; i < NB_B; i++) if (!be_n_b[i]) mem_b[addr_b][8*i +: 8] = dq_b[8*i +: 8];

    // ---------------- scoreboard push on accept ----------------
    always @(posedge clk) begin
        if (!rst && req_valid_a && req_ready_a) begin
            logic [DW_A-1:0] m, w;
            exp_t e;
            w = sh_a[req_addr_a];
            for (int i = 0; i < NB_A; i++) m[8*i +: 8] = {8{req_be_a[i]}};
            e.is_rd = !req_we_a;
            e.acc   = cyc;
            e.data  = 32'(w & m);
            if (req_we_a) sh_a[req_addr_a] = (w & ~m) | (req_wdata_a & m);
            q_a.push_back(e);
        end
        if (!rst && req_valid_b && req_ready_b) begin
            logic [DW_B-1:0] m, w;
            exp_t e;
            w = sh_b[req_addr_b];
            for (int i = 0; i < NB_B; i++) m[8*i +: 8] = {8{req_be_b[i]}};
            e.is_rd = !req_we_b;
            e.acc   = cyc;
            e.data  = w & m;
            if (req_we_b) sh_b[req_addr_b] = (w & ~m) | (req_wdata_b & m);
            q_b.push_back(e);
        end
    end

    // ---------------- scoreboard pop on response ----------------
    always @(negedge clk) begin
        if (!rst && rsp_valid_a) begin
            exp_t e;
            n_cmp++;
            if (q_a.size() == 0) begin
                n_fail++; $display("FAIL sb_a_unexpected_rsp: got rsp_valid, expected none");
            end else begin
                e = q_a.pop_front();
                n_cmp++;
                if (cyc - e.acc != (e.is_rd ? RW_A + 1 : WW_A + 1)) begin
                    n_fail++; $display("FAIL sb_a_latency: got %0d, expected %0d", cyc - e.acc, e.is_rd ? RW_A + 1 : WW_A + 1);
                end
                if (e.is_rd) begin
                    n_cmp++;
                    if (rsp_rdata_a !== e.data[DW_A-1:0]) begin
                        n_fail++; $display("FAIL sb_a_rdata: got %h, expected %h", rsp_rdata_a, e.data[DW_A-1:0]);
                    end
                end
            end
        end
        if (!rst && rsp_valid_b) begin
            exp_t e;
            n_cmp++;
            if (q_b.size() == 0) begin
                n_fail++; $display("FAIL sb_b_unexpected_rsp: got rsp_valid, expected none");
            end else begin
                e = q_b.pop_front();
                n_cmp++;
                if (cyc - e.acc != (e.is_rd ? RW_B + 1 : WW_B + 1)) begin
                    n_fail++; $display("FAIL sb_b_latency: got %0d, expected %0d", cyc - e.acc, e.is_rd ? RW_B + 1 : WW_B + 1);
                end
                if (e.is_rd) begin
                    n_cmp++;
                    if (rsp_rdata_b !== e.data) begin
                        n_fail++; $display("FAIL sb_b_rdata: got %h, expected %h", rsp_rdata_b, e.data);
                    end
                end
            end
        end
    end

    // ---------------- pin protocol monitor on DUT A ----------------
    logic            prev_ce = 1'b1, prev_drive = 1'b0;
    logic [AW_A-1:0] prev_addr = '0;
    logic [NB_A-1:0] prev_be = '1;

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (!oe_n_a && (!we_n_a || dut_a.drive_en)) begin
                n_fail++; $display("FAIL oe_conflict: oe_n=%b we_n=%b drive=%b, required oe_n low alone", oe_n_a, we_n_a, dut_a.drive_en);
            end
            if (!prev_ce && !ce_n_a) begin
                n_cmp++;
                if (addr_a !== prev_addr || be_n_a !== prev_be) begin
                    n_fail++; $display("FAIL addr_be_stable: addr %h->%h be_n %b->%b, required unchanged", prev_addr, addr_a, prev_be, be_n_a);
                end
            end
            if (dut_a.drive_en && !prev_drive) begin
                n_cmp++;
                if (prev_ce !== 1'b1) begin
                    n_fail++; $display("FAIL turnaround: prior ce_n=%b, required 1", prev_ce);
                end
            end
        end
        prev_ce    <= ce_n_a;
        prev_drive <= dut_a.drive_en;
        prev_addr  <= addr_a;
        prev_be    <= be_n_a;
    end

    // ---------------- drivers ----------------
    task automatic issue_a(input logic we, input logic [AW_A-1:0] addr, input logic [DW_A-1:0] wd,
                           input logic [NB_A-1:0] be, output int acc);
        int n;
        req_we_a = we; req_addr_a = addr; req_wdata_a = wd; req_be_a = be; req_valid_a = 1'b1;
        n = 0;
        while (!req_ready_a && n < 64) begin @(negedge clk); n++; end
        if (!req_ready_a) begin
            n_cmp++; n_fail++; $display("FAIL issue_a_timeout: ready=0 after %0d cycles, required 1", n);
        end
        acc = cyc;
        @(negedge clk);
    endtask

    task automatic issue_b(input logic we, input logic [AW_B-1:0] addr, input logic [DW_B-1:0] wd,
                           input logic [NB_B-1:0] be, output int acc);
        int n;
        req_we_b = we; req_addr_b = addr; req_wdata_b = wd; req_be_b = be; req_valid_b = 1'b1;
        n = 0;
        while (!req_ready_b && n < 64) begin @(negedge clk); n++; end
        if (!req_ready_b) begin
            n_cmp++; n_fail++; $display("FAIL issue_b_timeout: ready=0 after %0d cycles, required 1", n);
        end
        acc = cyc;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || !req_ready_a || !req_ready_b) && n < max_cyc) begin
            @(negedge clk); n++;
        end
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++; $display("FAIL drain_timeout: pending a=%0d b=%0d, required 0", q_a.size(), q_b.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ce_n_a, oe_n_a, we_n_a, be_n_a} !== 5'b11111) begin
            n_fail++; $display("FAIL reset_strobes: got %b, required 11111", {ce_n_a, oe_n_a, we_n_a, be_n_a});
        end
        n_cmp++;
        if (addr_a !== '0 || rsp_valid_a !== 1'b0 || rsp_rdata_a !== '0) begin
            n_fail++; $display("FAIL reset_regs: addr=%h rsp_valid=%b rdata=%h, required 0/0/0", addr_a, rsp_valid_a, rsp_rdata_a);
        end
        n_cmp++;
        if (req_ready_a !== 1'b0 || dut_a.drive_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_drive: ready=%b drive=%b, required 0/0", req_ready_a, dut_a.drive_en);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b, required 1", req_ready_a);
        end
    endtask

    task automatic test_write_read();
        int t, wlow;
        issue_a(1'b1, 9'h005, 16'hA55A, 2'b11, t);
        req_valid_a = 1'b0;
        wlow = 0;
        for (int i = 0; i < 8; i++) begin
            if (!we_n_a) wlow++;
            @(negedge clk);
        end
        n_cmp++;
        if (wlow != WW_A) begin
            n_fail++; $display("FAIL we_low_cycles: got %0d, required %0d", wlow, WW_A);
        end
        issue_a(1'b0, 9'h005, 16'h0000, 2'b11, t);
        req_valid_a = 1'b0;
        drain(50);
    endtask

    task automatic test_byte_lanes();
        int t;
        issue_a(1'b1, 9'h00A, 16'h1234, 2'b11, t);
        issue_a(1'b1, 9'h00A, 16'hFF00, 2'b10, t);
        issue_a(1'b0, 9'h00A, 16'h0000, 2'b11, t);
        issue_a(1'b0, 9'h00A, 16'h0000, 2'b01, t);
        req_valid_a = 1'b0;
        drain(80);
        n_cmp++;
        if (rsp_rdata_a !== 16'h0034) begin
            n_fail++; $display("FAIL byte_lane_low: got %h, required 0034", rsp_rdata_a);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2;
        issue_a(1'b0, 9'h001, 16'h0000, 2'b11, t0);
        issue_a(1'b1, 9'h002, 16'hBEEF, 2'b11, t1);
        issue_a(1'b0, 9'h002, 16'h0000, 2'b11, t2);
        req_valid_a = 1'b0;
        n_cmp++;
        if (t1 - t0 != RW_A + 2) begin
            n_fail++; $display("FAIL b2b_read_spacing: got %0d, required %0d", t1 - t0, RW_A + 2);
        end
        n_cmp++;
        if (t2 - t1 != WW_A + 2) begin
            n_fail++; $display("FAIL b2b_write_spacing: got %0d, required %0d", t2 - t1, WW_A + 2);
        end
        drain(50);
        n_cmp++;
        if (rsp_rdata_a !== 16'hBEEF) begin
            n_fail++; $display("FAIL b2b_final_rdata: got %h, required BEEF", rsp_rdata_a);
        end
    endtask

    task automatic test_zero_be();
        int t, pulses, bad_be;
        issue_a(1'b0, 9'h005, 16'h0000, 2'b00, t);
        req_valid_a = 1'b0;
        pulses = 0;
        bad_be = 0;
        for (int i = 0; i < 8; i++) begin
            if (be_n_a !== 2'b11) bad_be++;
            if (rsp_valid_a) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad_be != 0) begin
            n_fail++; $display("FAIL zero_be_lanes: %0d cycles with be_n active, required 0", bad_be);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL zero_be_pulses: got %0d, required 1", pulses);
        end
        n_cmp++;
        if (rsp_rdata_a !== 16'h0000) begin
            n_fail++; $display("FAIL zero_be_rdata: got %h, required 0000", rsp_rdata_a);
        end
    endtask

    task automatic test_sweep();
        int t;
        issue_b(1'b1, 12'hFFF, 32'hDEADBEEF, 4'b0101, t);
        issue_b(1'b0, 12'hFFF, 32'h0, 4'b1111, t);
        req_valid_b = 1'b0;
        drain(50);
        n_cmp++;
        if (rsp_rdata_b !== 32'h00AD00EF) begin
            n_fail++; $display("FAIL sweep_rdata: got %h, required 00AD00EF", rsp_rdata_b);
        end
    endtask

    task automatic test_reset_mid_write();
        int t, pulses;
        issue_a(1'b1, 9'h007, 16'h1111, 2'b11, t);
        req_valid_a = 1'b0;
        n_cmp++;
        if (we_n_a !== 1'b0) begin
            n_fail++; $display("FAIL midwr_in_wr: we_n=%b, required 0", we_n_a);
        end
        rst = 1'b1;
        #1;
        q_a.delete();
        n_cmp++;
        if (we_n_a !== 1'b1 || ce_n_a !== 1'b1 || dut_a.drive_en !== 1'b0) begin
            n_fail++; $display("FAIL midwr_release: we_n=%b ce_n=%b drive=%b, required 1/1/0", we_n_a, ce_n_a, dut_a.drive_en);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready_a !== 1'b1) begin
            n_fail++; $display("FAIL midwr_ready: got %b, required 1", req_ready_a);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid_a) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL midwr_no_rsp: got %0d pulses, required 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_zero_be();
        test_sweep();
        test_reset_mid_write();
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++; $display("FAIL final_pending: a=%0d b=%0d, required 0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
